// File: rtl/cursor_move_engine.sv
// cursor_move_engine
// Round-robin movement engine for CHANNELS independent cursors. On every
// rising edge of the frame tick it walks through the channels in order. For
// each one it asks the shared sprite drawer to clear the old sprite, moves the
// cursor on both axes at once with clamping, and then asks for a redraw.
//
// Optional feature: define CURSOR_MOVE_ACCEL_EN to give each channel a
// saturating hold counter. The counter scales the step to 1x, 2x or 4x STEP,
// depending on how many consecutive frames that cursor has been moving.
module cursor_move_engine #(
  parameter int CHANNELS    = 2,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 155,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 115,
  parameter int X_INIT      = 76,
  parameter int Y_INIT      = 56,
  parameter int STEP        = 2,
  parameter int ACCEL_TICKS = 8
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            tick,
  input  logic [4*CHANNELS-1:0]                           btn_n,
  input  logic                                            draw_done,
  output logic [2:0]                                      state,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
  output logic                                            clear_req,
  output logic                                            draw_req,
  output logic [X_W-1:0]                                  cur_x,
  output logic [Y_W-1:0]                                  cur_y,
  output logic [X_W*CHANNELS-1:0]                         pos_x,
  output logic [Y_W*CHANNELS-1:0]                         pos_y,
  output logic                                            overrun
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int XE_W = X_W + 2;
  localparam int YE_W = Y_W + 2;

  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [XE_W-1:0] X_MIN_E  = XE_W'(X_MIN);
  localparam logic [XE_W-1:0] X_MAX_E  = XE_W'(X_MAX);
  localparam logic [YE_W-1:0] Y_MIN_E  = YE_W'(Y_MIN);
  localparam logic [YE_W-1:0] Y_MAX_E  = YE_W'(Y_MAX);
  localparam logic [X_W-1:0]  X_INIT_V = X_W'(X_INIT);
  localparam logic [Y_W-1:0]  Y_INIT_V = Y_W'(Y_INIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MOVE  = 3'd2,
    DRAW  = 3'd3,
    NEXT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_sel_q, ch_sel_d;
  logic            tick_q, tick_d;
  logic            tick_rise;
  logic            overrun_q, overrun_d;

  logic [X_W-1:0]  pos_x_q [CHANNELS];
  logic [X_W-1:0]  pos_x_d [CHANNELS];
  logic [Y_W-1:0]  pos_y_q [CHANNELS];
  logic [Y_W-1:0]  pos_y_d [CHANNELS];

  // Buttons (active-high) and position of the channel being serviced.
  logic [3:0]      btn_sel;
  logic [X_W-1:0]  x_sel;
  logic [Y_W-1:0]  y_sel;

  // Movement datapath, two guard bits wide so sums and differences never wrap.
  int              step_i;
  logic [XE_W-1:0] step_x, x_ext, x_sum, x_new;
  logic [YE_W-1:0] step_y, y_ext, y_sum, y_new;
  logic [X_W-1:0]  x_next;
  logic [Y_W-1:0]  y_next;

`ifdef CURSOR_MOVE_ACCEL_EN
  localparam int HOLD_W = $clog2(2*ACCEL_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_L1  = HOLD_W'(ACCEL_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(2*ACCEL_TICKS);

  logic [HOLD_W-1:0] hold_q [CHANNELS];
  logic [HOLD_W-1:0] hold_d [CHANNELS];
  logic [HOLD_W-1:0] hold_sel;
  logic              any_pressed;
`endif

  // The tick history simply follows the tick level every cycle.
  always_comb begin
    tick_d    = tick;
    tick_rise = tick & ~tick_q;
  end

  // Pick out the buttons, position and hold count of the channel in service.
  always_comb begin
    btn_sel  = 4'b0000;
    x_sel    = pos_x_q[0];
    y_sel    = pos_y_q[0];
`ifdef CURSOR_MOVE_ACCEL_EN
    hold_sel = hold_q[0];
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel_q == CH_W'(c)) begin
        btn_sel  = ~btn_n[4*c +: 4];
        x_sel    = pos_x_q[c];
        y_sel    = pos_y_q[c];
`ifdef CURSOR_MOVE_ACCEL_EN
        hold_sel = hold_q[c];
`endif
      end
    end
  end

  // Step size: fixed by default. With acceleration it grows with the hold count.
  always_comb begin
    step_i = STEP;
`ifdef CURSOR_MOVE_ACCEL_EN
    if (hold_sel >= HOLD_SAT) begin
      step_i = 4*STEP;
    end else if (hold_sel >= HOLD_L1) begin
      step_i = 2*STEP;
    end
`endif
    step_x = XE_W'(step_i);
    step_y = YE_W'(step_i);
  end

  // Clamped move on both axes. RIGHT beats LEFT and DOWN beats UP.
  always_comb begin
    x_ext = {2'b00, x_sel};
    x_sum = x_ext + step_x;
    x_new = x_ext;
    if (btn_sel[0]) begin
      x_new = (x_sum > X_MAX_E) ? X_MAX_E : x_sum;
    end else if (btn_sel[3]) begin
      x_new = (x_ext < (X_MIN_E + step_x)) ? X_MIN_E : (x_ext - step_x);
    end
    x_next = x_new[X_W-1:0];

    y_ext = {2'b00, y_sel};
    y_sum = y_ext + step_y;
    y_new = y_ext;
    if (btn_sel[1]) begin
      y_new = (y_sum > Y_MAX_E) ? Y_MAX_E : y_sum;
    end else if (btn_sel[2]) begin
      y_new = (y_ext < (Y_MIN_E + step_y)) ? Y_MIN_E : (y_ext - step_y);
    end
    y_next = y_new[Y_W-1:0];
  end

  // Only the serviced channel changes position, and only during MOVE.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      pos_x_d[c] = pos_x_q[c];
      pos_y_d[c] = pos_y_q[c];
      if ((state_q == MOVE) && (ch_sel_q == CH_W'(c))) begin
        pos_x_d[c] = x_next;
        pos_y_d[c] = y_next;
      end
    end
  end

`ifdef CURSOR_MOVE_ACCEL_EN
  // Hold counter: counts up (saturating) while the cursor moves, cleared on idle frames.
  always_comb begin
    any_pressed = |btn_sel;
    for (int c = 0; c < CHANNELS; c++) begin
      hold_d[c] = hold_q[c];
      if ((state_q == MOVE) && (ch_sel_q == CH_W'(c))) begin
        if (!any_pressed) begin
          hold_d[c] = '0;
        end else if (hold_sel != HOLD_SAT) begin
          hold_d[c] = hold_sel + HOLD_W'(1);
        end
      end
    end
  end
`endif

  // Frame sequencing: a new frame starts only from IDLE. Ticks that arrive while busy are dropped.
  always_comb begin
    state_d   = state_q;
    ch_sel_d  = ch_sel_q;
    overrun_d = tick_rise && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (tick_rise) begin
          state_d  = CLEAR;
          ch_sel_d = '0;
        end
      end
      CLEAR: begin
        if (draw_done) begin
          state_d = MOVE;
        end
      end
      MOVE: begin
        state_d = DRAW;
      end
      DRAW: begin
        if (draw_done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (ch_sel_q == LAST_CH) begin
          state_d  = IDLE;
          ch_sel_d = '0;
        end else begin
          state_d  = CLEAR;
          ch_sel_d = ch_sel_q + CH_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        ch_sel_d = '0;
      end
    endcase
  end

  // State, tick history and positions. Reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_sel_q  <= '0;
      tick_q    <= 1'b1;
      overrun_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        pos_x_q[c] <= X_INIT_V;
        pos_y_q[c] <= Y_INIT_V;
      end
    end else begin
      state_q   <= state_d;
      ch_sel_q  <= ch_sel_d;
      tick_q    <= tick_d;
      overrun_q <= overrun_d;
      for (int c = 0; c < CHANNELS; c++) begin
        pos_x_q[c] <= pos_x_d[c];
        pos_y_q[c] <= pos_y_d[c];
      end
    end
  end

`ifdef CURSOR_MOVE_ACCEL_EN
  // Hold counters start from zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        hold_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        hold_q[c] <= hold_d[c];
      end
    end
  end
`endif

  // Flatten positions for the drawer and expose the serviced channel.
  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pos_x[c*X_W +: X_W] = pos_x_q[c];
      pos_y[c*Y_W +: Y_W] = pos_y_q[c];
    end
  end

  assign state     = state_q;
  assign ch_sel    = ch_sel_q;
  assign clear_req = (state_q == CLEAR);
  assign draw_req  = (state_q == DRAW);
  assign cur_x     = x_sel;
  assign cur_y     = y_sel;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cursor_move_engine.sv
// tb_cursor_move_engine
// Self-checking bench for cursor_move_engine. A frame-level reference model
// tracks which phase each frame is in, which channel is being serviced and the
// clamped integer positions. A compare process checks every DUT output against
// the model on each falling clock edge. Directed scenarios pin the model with
// hand-computed literal values. A randomized phase follows, with random
// buttons, ticks, drawer latency and resets.
// Build with CURSOR_MOVE_ACCEL_EN defined to check the acceleration feature.
`timescale 1ns/1ps
module tb_cursor_move_engine;

  localparam int CHANNELS    = 2;
  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int X_MIN       = 0;
  localparam int X_MAX       = 155;
  localparam int Y_MIN       = 0;
  localparam int Y_MAX       = 115;
  localparam int X_INIT      = 76;
  localparam int Y_INIT      = 56;
  localparam int STEP        = 2;
  localparam int ACCEL_TICKS = 8;
  localparam int CH_W        = 1;

  localparam logic [3:0] B_RIGHT = 4'b0001;
  localparam logic [3:0] B_DOWN  = 4'b0010;
  localparam logic [3:0] B_UP    = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b1000;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    tick;
  logic [4*CHANNELS-1:0]   btn_n;
  logic                    draw_done;
  logic [2:0]              state;
  logic [CH_W-1:0]         ch_sel;
  logic                    clear_req;
  logic                    draw_req;
  logic [X_W-1:0]          cur_x;
  logic [Y_W-1:0]          cur_y;
  logic [X_W*CHANNELS-1:0] pos_x;
  logic [Y_W*CHANNELS-1:0] pos_y;
  logic                    overrun;

  cursor_move_engine #(
    .CHANNELS(CHANNELS), .X_W(X_W), .Y_W(Y_W),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .STEP(STEP), .ACCEL_TICKS(ACCEL_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_n(btn_n), .draw_done(draw_done),
    .state(state), .ch_sel(ch_sel), .clear_req(clear_req), .draw_req(draw_req),
    .cur_x(cur_x), .cur_y(cur_y), .pos_x(pos_x), .pos_y(pos_y), .overrun(overrun)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state. Phase numbers are the published state codes:
  // 0 idle, 1 clear, 2 move, 3 draw, 4 next.
  int mState;
  int mCh;
  int mX [CHANNELS];
  int mY [CHANNELS];
`ifdef CURSOR_MOVE_ACCEL_EN
  int mHold [CHANNELS];
`endif
  bit mOvr;
  bit mTickPrev;
  bit mRise;
  bit chkEn = 1'b0;

  // Drawer responder settings: fixedLat >= 0 uses that latency, otherwise a random one.
  int fixedLat = 2;
  int respCnt  = 0;
  int respLat  = 0;

  // Per-cycle trace of one frame, captured by runFrame.
  int qState[$];
  int qCh[$];
  int qX[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's worth of inputs just after the falling edge.
  task automatic applyStimulus(input logic rstV, input logic tickV, input logic [4*CHANNELS-1:0] act);
    @(negedge clk);
    #1;
    reset = rstV;
    tick  = tickV;
    btn_n = ~act;
  endtask

  function automatic logic [4*CHANNELS-1:0] btnFor(input int ch, input logic [3:0] b);
    logic [4*CHANNELS-1:0] v;
    v = '0;
    v[4*ch +: 4] = b;
    return v;
  endfunction

  // Apply one MOVE to the model: clamped integer arithmetic, RIGHT and DOWN take priority.
  task automatic modelMove(input int c);
    logic [3:0] b;
    int step;
    b = ~btn_n[4*c +: 4];
    step = STEP;
`ifdef CURSOR_MOVE_ACCEL_EN
    if (mHold[c] >= 2*ACCEL_TICKS) step = 4*STEP;
    else if (mHold[c] >= ACCEL_TICKS) step = 2*STEP;
    if (b == 4'b0000) mHold[c] = 0;
    else if (mHold[c] < 2*ACCEL_TICKS) mHold[c] = mHold[c] + 1;
`endif
    if (b[0]) mX[c] = (mX[c] + step > X_MAX) ? X_MAX : mX[c] + step;
    else if (b[3]) mX[c] = (mX[c] - step < X_MIN) ? X_MIN : mX[c] - step;
    if (b[1]) mY[c] = (mY[c] + step > Y_MAX) ? Y_MAX : mY[c] + step;
    else if (b[2]) mY[c] = (mY[c] - step < Y_MIN) ? Y_MIN : mY[c] - step;
  endtask

  // Reference model advances on each rising edge from the inputs that are stable at that edge.
  always @(posedge clk) begin
    mRise = tick && !mTickPrev;
    if (reset) begin
      mState    = 0;
      mCh       = 0;
      mOvr      = 1'b0;
      mTickPrev = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        mX[c] = X_INIT;
        mY[c] = Y_INIT;
`ifdef CURSOR_MOVE_ACCEL_EN
        mHold[c] = 0;
`endif
      end
    end else begin
      mOvr = mRise && (mState != 0);
      case (mState)
        0: if (mRise) begin mState = 1; mCh = 0; end
        1: if (draw_done) mState = 2;
        2: begin modelMove(mCh); mState = 3; end
        3: if (draw_done) mState = 4;
        4: begin
          if (mCh == CHANNELS - 1) begin mState = 0; mCh = 0; end
          else begin mCh = mCh + 1; mState = 1; end
        end
        default: mState = 0;
      endcase
      mTickPrev = tick;
    end
  end

  // Compare every DUT output against the model once per cycle, on the falling edge.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("state", int'(state), mState);
      checkOutput("ch_sel", int'(ch_sel), mCh);
      checkOutput("clear_req", int'(clear_req), (mState == 1) ? 1 : 0);
      checkOutput("draw_req", int'(draw_req), (mState == 3) ? 1 : 0);
      checkOutput("cur_x", int'(cur_x), mX[mCh]);
      checkOutput("cur_y", int'(cur_y), mY[mCh]);
      checkOutput("overrun", int'(overrun), int'(mOvr));
      for (int c = 0; c < CHANNELS; c++) begin
        checkOutput("pos_x", int'(pos_x[c*X_W +: X_W]), mX[c]);
        checkOutput("pos_y", int'(pos_y[c*Y_W +: Y_W]), mY[c]);
      end
    end
  end

  // Drawer stand-in: acknowledges each clear/draw request after a set number of cycles.
  always begin
    @(negedge clk);
    #2;
    if (clear_req || draw_req) begin
      if (respCnt == 0) respLat = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
      respCnt++;
      draw_done = (respCnt > respLat);
    end else begin
      respCnt   = 0;
      draw_done = 1'b0;
    end
  end

  // Start one frame with the given buttons held, then wait (bounded) for the return to idle.
  task automatic runFrame(input logic [4*CHANNELS-1:0] act);
    int  n;
    bit  started;
    bit  done;
    qState.delete();
    qCh.delete();
    qX.delete();
    applyStimulus(1'b0, 1'b0, act);
    applyStimulus(1'b0, 1'b1, act);
    n = 0; started = 1'b0; done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      qState.push_back(int'(state));
      qCh.push_back(int'(ch_sel));
      qX.push_back(int'(cur_x));
      if (state != 3'd0) started = 1'b1;
      else if (started) done = 1'b1;
    end
    if (!done) checkOutput("frame_timeout", n, 0);
  endtask

  // Safety net in case something stalls outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int seqExp [17];
    int n;
    int ovrCnt;
    int clrX;
    int drwX;
    reset     = 1'b1;
    tick      = 1'b1;
    btn_n     = '1;
    draw_done = 1'b0;
    seqExp = '{1, 1, 1, 2, 3, 3, 3, 4, 1, 1, 1, 2, 3, 3, 3, 4, 0};

    // Reset with tick held high, then release with tick still high: no edge, no frame.
    applyStimulus(1'b1, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, '0);
    chkEn = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, '0);
    @(negedge clk);
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_x0", int'(pos_x[0 +: X_W]), 76);
    checkOutput("reset_y0", int'(pos_y[0 +: Y_W]), 56);
    checkOutput("reset_x1", int'(pos_x[X_W +: X_W]), 76);
    checkOutput("reset_overrun", int'(overrun), 0);

    // Idle frame: fixed state sequence for both channels, positions untouched.
    runFrame('0);
    checkOutput("seq_len", qState.size(), 17);
    for (int i = 0; i < 17 && i < qState.size(); i++) checkOutput("seq_state", qState[i], seqExp[i]);
    checkOutput("idle_x0", int'(pos_x[0 +: X_W]), 76);
    checkOutput("idle_y1", int'(pos_y[Y_W +: Y_W]), 56);

    // Diagonal move of channel 0 only; cur_x shows old then new position.
    runFrame(btnFor(0, B_RIGHT | B_DOWN));
    clrX = -1; drwX = -1;
    for (int i = 0; i < qState.size(); i++) begin
      if (qState[i] == 1 && qCh[i] == 0 && clrX < 0) clrX = qX[i];
      if (qState[i] == 3 && qCh[i] == 0 && drwX < 0) drwX = qX[i];
    end
    checkOutput("clear_cur_x", clrX, 76);
    checkOutput("draw_cur_x", drwX, 78);
    checkOutput("diag_x0", int'(pos_x[0 +: X_W]), 78);
    checkOutput("diag_y0", int'(pos_y[0 +: Y_W]), 58);
    checkOutput("diag_x1", int'(pos_x[X_W +: X_W]), 76);
    checkOutput("diag_y1", int'(pos_y[Y_W +: Y_W]), 56);

    // Walk channel 0 to the right edge, then test RIGHT+LEFT priority and clamping.
    n = 0;
    while (mX[0] < 154 && n < 100) begin runFrame(btnFor(0, B_RIGHT)); n++; end
`ifndef CURSOR_MOVE_ACCEL_EN
    checkOutput("walk_x0", int'(pos_x[0 +: X_W]), 154);
`endif
    runFrame(btnFor(0, B_RIGHT | B_LEFT));
    checkOutput("right_wins_clamp", int'(pos_x[0 +: X_W]), 155);
    runFrame(btnFor(0, B_RIGHT));
    checkOutput("stay_at_xmax", int'(pos_x[0 +: X_W]), 155);

    // Walk channel 0 to the top, then channel 1 to the left edge.
    n = 0;
    while (mY[0] > 0 && n < 100) begin runFrame(btnFor(0, B_UP)); n++; end
    runFrame(btnFor(0, B_UP));
    checkOutput("stay_at_ymin", int'(pos_y[0 +: Y_W]), 0);
    n = 0;
    while (mX[1] > 0 && n < 100) begin runFrame(btnFor(1, B_LEFT)); n++; end
    runFrame(btnFor(1, B_LEFT));
    checkOutput("stay_at_xmin", int'(pos_x[X_W +: X_W]), 0);

    // Second tick edge during DRAW: one-cycle overrun, frame completes, no new frame.
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
    n = 0;
    while (state != 3'd3 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) checkOutput("wait_draw_timeout", n, 0);
    #1 tick = 1'b0;
    applyStimulus(1'b0, 1'b1, '0);
    ovrCnt = 0; n = 0;
    while (state != 3'd0 && n < 100) begin
      @(negedge clk);
      n++;
      if (overrun) ovrCnt++;
    end
    if (n >= 100) checkOutput("overrun_frame_timeout", n, 0);
    checkOutput("overrun_pulses", ovrCnt, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);
    @(negedge clk);
    checkOutput("no_queued_frame", int'(state), 0);

    // Reset in the middle of channel 1's DRAW.
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, btnFor(1, B_DOWN));
    n = 0;
    while (!(state == 3'd3 && ch_sel == 1'b1) && n < 80) begin @(negedge clk); n++; end
    if (n >= 80) checkOutput("wait_draw1_timeout", n, 0);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_state", int'(state), 0);
    checkOutput("midreset_ch_sel", int'(ch_sel), 0);
    checkOutput("midreset_draw_req", int'(draw_req), 0);
    checkOutput("midreset_x0", int'(pos_x[0 +: X_W]), 76);
    checkOutput("midreset_y0", int'(pos_y[0 +: Y_W]), 56);
    checkOutput("midreset_x1", int'(pos_x[X_W +: X_W]), 76);
    checkOutput("midreset_y1", int'(pos_y[Y_W +: Y_W]), 56);
    applyStimulus(1'b0, 1'b0, '0);

    // Nine consecutive RIGHT frames from the reset position.
    for (int i = 0; i < 8; i++) runFrame(btnFor(0, B_RIGHT));
    checkOutput("hold8_x0", int'(pos_x[0 +: X_W]), 92);
    runFrame(btnFor(0, B_RIGHT));
`ifdef CURSOR_MOVE_ACCEL_EN
    checkOutput("hold9_x0", int'(pos_x[0 +: X_W]), 96);
`else
    checkOutput("hold9_x0", int'(pos_x[0 +: X_W]), 94);
`endif

    // Randomized phase: random buttons, tick toggles, drawer latency and occasional reset.
    fixedLat = -1;
    for (int i = 0; i < 1500; i++) begin
      logic [4*CHANNELS-1:0] b;
      logic r;
      logic t;
      b = (4*CHANNELS)'($urandom);
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 5) == 0) ? ~tick : tick;
      applyStimulus(r, t, b);
    end
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
